// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for param_fifo and its storage array.
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 16;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic almost_full;
        logic full;
    } fifo_flags_t;

    // count must represent 0..DEPTH inclusive, hence DEPTH+1 states
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage with one write port and one registered read port.
module fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage array write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register: holds its value unless a read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with registered occupancy/threshold flags and registered read data.
// Optional sticky overflow/underflow flags are enabled by defining PARAM_FIFO_ERR_FLAGS_EN.
module param_fifo
    import fifo_pkg::*;
#(
    parameter  int WIDTH    = DEFAULT_WIDTH,
    parameter  int DEPTH    = DEFAULT_DEPTH,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 2,
    localparam int CW       = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam int            AW        = ptr_width(DEPTH);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic          wr_acc_s;
    logic          rd_acc_s;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fifo_flags_t   flags_q, flags_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    function automatic fifo_flags_t decode_flags(input logic [CW-1:0] cnt);
        fifo_flags_t f;
        f.empty        = (cnt == '0);
        f.full         = (cnt == DEPTH_CNT);
        f.almost_full  = (int'(cnt) >= AF_LEVEL);
        f.almost_empty = (int'(cnt) <= AE_LEVEL);
        return f;
    endfunction

    // Explicit wrap so DEPTH need not be a power of two
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end else begin
            return p + AW'(1);
        end
    endfunction

    // Accept decisions, pointer advance and next occupancy.
    always_comb begin
        wr_acc_s = cs && wr_en && !flags_q.full;
        rd_acc_s = cs && rd_en && !flags_q.empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc_s) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        flags_d = decode_flags(count_d);
    end

`ifdef PARAM_FIFO_ERR_FLAGS_EN
    // Sticky error flags; a new error on the clearing edge wins over err_clr.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (cs && wr_en && flags_q.full) begin
            ovf_d = 1'b1;
        end else if (err_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (cs && rd_en && flags_q.empty) begin
            unf_d = 1'b1;
        end else if (err_clr) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr;

    // Error flags disabled: held at zero.
    always_comb begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
    end
`endif

    // Control state registers; flags are registered alongside count so they track it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= '{empty: 1'b1, almost_empty: 1'b1, almost_full: 1'b0, full: 1'b0};
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (wr_acc_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_en_i   (rd_acc_s),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (data_out)
    );

    assign empty        = flags_q.empty;
    assign full         = flags_q.full;
    assign almost_empty = flags_q.almost_empty;
    assign almost_full  = flags_q.almost_full;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (DEPTH=8): directed table, corner sequences, random vs queue model.
module tb_param_fifo;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;
    localparam int CW = 4;

`ifdef PARAM_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          cs      = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;
    logic [CW-1:0] count;

    param_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .err_clr(err_clr),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain queue of stored words plus last-read word and sticky flags
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout = '0;
    bit           m_ov   = 1'b0;
    bit           m_un   = 1'b0;

    typedef struct {
        bit          c, w, r;
        logic [31:0] din;
        int          cnt;
        logic [31:0] dout;
        bit          emp, ful, ae, af;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(bit c, bit w, bit r, logic [31:0] din, int cnt,
                                logic [31:0] dout, bit emp, bit ful, bit ae, bit af);
        vec_t v;
        v.c = c; v.w = w; v.r = r; v.din = din; v.cnt = cnt; v.dout = dout;
        v.emp = emp; v.ful = ful; v.ae = ae; v.af = af;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
    endtask

    task automatic model_edge(input bit c, input bit w, input bit r, input logic [31:0] d, input bit clr);
        int n;
        bit was_full, was_empty;
        n         = mq.size();
        was_full  = (n == D);
        was_empty = (n == 0);
        if (ERR_EN) begin
            if (c && w && was_full) m_ov = 1'b1;
            else if (clr)           m_ov = 1'b0;
            if (c && r && was_empty) m_un = 1'b1;
            else if (clr)            m_un = 1'b0;
        end
        if (c && r && !was_empty) m_dout = mq.pop_front();
        if (c && w && !was_full)  mq.push_back(d);
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"},        32'(count),        32'(n));
        chk({tag, ".empty"},        32'(empty),        32'(n == 0));
        chk({tag, ".full"},         32'(full),         32'(n == D));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, ".data_out"},     data_out,          m_dout);
        chk({tag, ".overflow"},     32'(overflow),     32'(m_ov));
        chk({tag, ".underflow"},    32'(underflow),    32'(m_un));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".count"},        32'(count),        32'd0);
        chk({tag, ".empty"},        32'(empty),        32'd1);
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
        chk({tag, ".full"},         32'(full),         32'd0);
        chk({tag, ".almost_full"},  32'(almost_full),  32'd0);
        chk({tag, ".data_out"},     data_out,          32'd0);
        chk({tag, ".overflow"},     32'(overflow),     32'd0);
        chk({tag, ".underflow"},    32'(underflow),    32'd0);
    endtask

    task automatic drive(input bit c, input bit w, input bit r, input logic [31:0] d, input bit clr);
        cs = c; wr_en = w; rd_en = r; data_in = d; err_clr = clr;
    endtask

    task automatic clock_edge(input bit c, input bit w, input bit r, input logic [31:0] d, input bit clr);
        @(posedge clk);
        model_edge(c, w, r, d, clr);
        #1;
    endtask

    task automatic step(input bit c, input bit w, input bit r, input logic [31:0] d, input bit clr);
        @(negedge clk);
        drive(c, w, r, d, clr);
        clock_edge(c, w, r, d, clr);
    endtask

    task automatic fill_to(input int n);
        for (int k = 0; k < 2 * D && mq.size() < n; k++) step(1'b1, 1'b1, 1'b0, $urandom, 1'b0);
    endtask

    task automatic drain_to(input int n);
        for (int k = 0; k < 2 * D && mq.size() > n; k++) step(1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
    endtask

    task automatic cmp_row(input int i);
        string t;
        t = $sformatf("row%0d", i);
        chk({t, ".count"},        32'(count),        32'(tbl[i].cnt));
        chk({t, ".data_out"},     data_out,          tbl[i].dout);
        chk({t, ".empty"},        32'(empty),        32'(tbl[i].emp));
        chk({t, ".full"},         32'(full),         32'(tbl[i].ful));
        chk({t, ".almost_empty"}, 32'(almost_empty), 32'(tbl[i].ae));
        chk({t, ".almost_full"},  32'(almost_full),  32'(tbl[i].af));
    endtask

    initial begin
        // Fill 1..8, one ignored cycle with cs=0, then drain 8 reads
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 32'h1,  1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 32'h2,  2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 32'h3,  3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 32'h4,  4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 32'h5,  5, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 32'h6,  6, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 32'h7,  7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 32'h8,  8, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 1'b1, 1'b1, 32'hFF, 8, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 32'h0,  7, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 32'h0,  6, 32'h2, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[11] = mk(1'b1, 1'b0, 1'b1, 32'h0,  5, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 32'h0,  4, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[13] = mk(1'b1, 1'b0, 1'b1, 32'h0,  3, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[14] = mk(1'b1, 1'b0, 1'b1, 32'h0,  2, 32'h6, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[15] = mk(1'b1, 1'b0, 1'b1, 32'h0,  1, 32'h7, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[16] = mk(1'b1, 1'b0, 1'b1, 32'h0,  0, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0);

        model_reset();
        #7;
        check_reset("reset");

        // Row 0 is applied while in reset so the first post-reset edge must take the write
        for (int i = 0; i < 17; i++) begin
            if (i == 0) begin
                @(negedge clk);
                drive(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].din, 1'b0);
                #2 rst = 1'b1;
                clock_edge(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].din, 1'b0);
            end else begin
                step(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].din, 1'b0);
            end
            cmp_row(i);
        end

        // Steady state at count 3 with simultaneous read/write; pointers wrap
        step(1'b1, 1'b1, 1'b0, 32'h11, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h22, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h33, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b1, 32'hA0 + 32'(i), 1'b0);
            check_model($sformatf("rw%0d", i));
        end
        chk("rw_count_held", 32'(count), 32'd3);

        // Overflow: dropped write, sticky hold, set-vs-clear priority, clear
        fill_to(D);
        step(1'b1, 1'b1, 1'b0, 32'hDEAD, 1'b0);
        check_model("ovf_set");
        chk("ovf_count", 32'(count), 32'd8);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_model("ovf_hold");
        step(1'b1, 1'b1, 1'b0, 32'hBEEF, 1'b1);
        check_model("ovf_set_with_clr");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_model("ovf_clr");
        step(1'b1, 1'b1, 1'b1, 32'h1234, 1'b0);
        check_model("full_rdwr");
        chk("full_rdwr_count", 32'(count), 32'd7);

        // Underflow: empty with read+write, only the write lands, no fall-through
        drain_to(0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h55, 1'b0);
        check_model("unf_set");
        chk("unf_count", 32'(count), 32'd1);
        step(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        check_model("unf_next_read");
        chk("unf_read_data", data_out, 32'h55);

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom_range(0, 15) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        // Asynchronous reset mid-cycle at count 5, then cs=0 must be inert
        drain_to(0);
        step(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        fill_to(5);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd5);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_reset("async_reset");
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b1, 32'h77, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h78, 1'b0);
        check_model("cs_low");
        check_reset("cs_low_reset_state");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, 32, data word width in bits (>=1).
REQ-002 Parameter DEPTH, 16, number of storage entries (>=2, need not be a power of two).
REQ-003 Parameter AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-006 Port rst, input, 1, reset; asynchronous, active-low.
REQ-007 Port cs, input, 1, chip select; rd_en/wr_en ignored when 0.
REQ-008 Port wr_en, input, 1, write request.
REQ-009 Port data_in, input, WIDTH, write data.
REQ-010 Port rd_en, input, 1, read request.
REQ-011 Port data_out, output, WIDTH, registered read data.
REQ-012 Port empty / full, output, 1 each, occupancy flags.
REQ-013 Port almost_empty / almost_full, output, 1 each, threshold flags.
REQ-014 Port count, output, $clog2(DEPTH+1), current occupancy.
REQ-015 Port err_clr, input, 1, clears sticky error flags.
REQ-016 Port overflow / underflow, output, 1 each, sticky error flags.

Function
REQ-017 Write accepted iff cs && wr_en && !full (pre-edge full); data_in stored at write pointer.
REQ-018 Read accepted iff cs && rd_en && !empty (pre-edge empty); head word loaded into data_out on that edge (1-cycle latency).
REQ-019 data_out holds its last value when no read is accepted.
REQ-020 Read and write accepted on same edge: count unchanged, both pointers advance.
REQ-021 Full with rd_en && wr_en: only read accepted; count decrements by 1.
REQ-022 Empty with rd_en && wr_en: only write accepted; data_out unchanged; no fall-through.
REQ-023 Pointers wrap from DEPTH-1 to 0; no power-of-two assumption.
REQ-024 count is registered; empty = (count==0), full = (count==DEPTH), almost flags per REQ-003/004, all decoded from registered count only.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 rst low asynchronously forces pointers=0, count=0, data_out=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-027 Reset mid-operation discards all stored entries; storage array contents need not be cleared.
REQ-028 First write is accepted on the first rising clk edge after rst deasserts.

Configuration
REQ-029 Macro PARAM_FIFO_ERR_FLAGS_EN defined: overflow sets on cs && wr_en && full, underflow sets on cs && rd_en && empty; both stay set until err_clr=1 on a clock edge or reset; a set condition coinciding with err_clr leaves the flag set.
REQ-030 Macro undefined: overflow and underflow tied to 0, err_clr ignored; ports still present.

Structure
REQ-031 Package fifo_pkg holds the default WIDTH/DEPTH constants and a count-width helper function.
REQ-032 Storage is a sub-module fifo_mem (1 write port, 1 registered read port, WIDTH x DEPTH); pointer/count/flag logic stays in param_fifo.

Verification (WIDTH=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2, macro defined)
REQ-033 Reset then write 0x1..0x8 -> count 1..8, almost_full at count 6, full at count 8, empty 0 after first write.
REQ-034 From full, read 8 times -> data_out 0x1..0x8 in order, each one cycle after read edge; empty=1 after 8th read.
REQ-035 Count=3, write 0xA and read simultaneously for 10 cycles -> count stays 3, pointers wrap, data order preserved.
REQ-036 Full, wr_en=1 data 0xDEAD -> write dropped, overflow=1 and held; err_clr pulse -> overflow=0.
REQ-037 Empty, rd_en=1 with wr_en=1 data 0x55 -> underflow=1, count=1, data_out unchanged; next read returns 0x55.
REQ-038 Count=5, assert rst low between edges -> outputs reach reset values immediately; cs=0 with rd_en/wr_en=1 afterwards -> no state change.
